intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
//
// PURPOSE
//   Interrupt controller feeding the OTTER MCU control FSM. Synchronizes and
//   edge-detects external sources, latches pending bits, applies an enable mask,
//   drives INTR to the FSM, and retires the request on int_taken / mret_exec.
//   Software reaches it through the MMIO bus. Cause is readable by the ISR.
//
// PARAMETERS
//   N_SRC     4    number of external interrupt sources (1..30)
//   TMR_W     32   width of optional timer counter/compare
//
// PORTS
//   clk         in   1       system clock
//   RST         in   1       reset, synchronous, active-high
//   src_in      in   N_SRC   async external sources, rising edge = request
//   io_wr       in   1       MMIO write strobe, one cycle
//   io_addr     in   3       MMIO word offset (byte addr [4:2])
//   io_wdata    in   32      MMIO write data
//   io_rdata    out  32      MMIO read data, combinational from io_addr
//   int_taken   in   1       FSM in INTRPT state (ack)
//   mret_exec   in   1       FSM executing MRET (end of service)
//   INTR        out  1       interrupt request to FSM
//   in_service  out  1       handler active; blocks further INTR
//   int_cause   out  5       index of source being serviced
//
// BEHAVIOUR
// - Line count NT = N_SRC, or N_SRC+1 with timer (timer = index N_SRC).
// - Reset: INTR=0, in_service=0, int_cause=0, io_rdata reads reset values;
//   enable, pending, sync flops, edge-history flops, timer cnt/cmp all 0.
// - Each src_in: 2-flop synchronizer then rising-edge detect vs previous
//   synced value. Pending bit sets on the 3rd clk edge after src_in rises.
//   Source held high through reset pends once after RST drops.
// - INTR = |(pending & enable) & ~in_service; combinational from regs only.
// - int_taken cycle with eligible set E = pending & enable nonzero:
//   sel = lowest set index of E (lowest index = highest priority);
//   next edge: pending[sel] cleared, int_cause = sel, in_service = 1.
//   E == 0 or in_service already 1: int_taken ignored, no state change.
// - mret_exec: in_service cleared next edge; int_cause held.
// - int_taken and mret_exec same cycle: int_taken wins (in_service = 1).
// - New edge on source sel in the same cycle it is cleared: set wins.
// - Register map (io_addr): 0 ENABLE RW [NT-1:0]; 1 PENDING R, W1C;
//   2 CAUSE R {in_service, 26'b0, int_cause}; 3 TMR_CMP RW; 4 TMR_CNT RW;
//   others read 0, writes ignored. Unused upper bits read 0.
// - PENDING W1C and hardware set same bit same cycle: set wins.
// - Writing ENABLE does not touch pending; masked pending bits persist.
// - RST mid-service: all state to reset values next edge, INTR drops.
//
// CONFIGURATION
//   INTC_TIMER_EN defined: internal timer source. TMR_CNT increments each
//   cycle; when TMR_CMP != 0 and TMR_CNT == TMR_CMP, TMR_CNT -> 0 and
//   pending[N_SRC] sets. TMR_CMP == 0 stops counting (holds). Write to
//   TMR_CNT or TMR_CMP takes priority over increment/wrap that cycle.
//   Undefined: NT = N_SRC, offsets 3/4 read 0, writes ignored, no timer logic.
//
// TESTING
// - RST, ENABLE=0x1, pulse src_in[0] 1 cycle -> INTR=1 3 edges later;
//   int_taken 1 cycle -> INTR=0, in_service=1, int_cause=0, PENDING=0.
// - ENABLE=0xF, src_in[3] and src_in[1] rise together -> int_taken gives
//   cause=1; mret_exec -> INTR=1 again; second int_taken gives cause=3.
// - ENABLE=0x0, edge on src_in[2] -> PENDING=0x4, INTR=0; write ENABLE=0x4
//   -> INTR=1; write PENDING=0x4 -> PENDING=0, INTR=0.
// - During in_service=1, edge on src_in[0] -> pending set, INTR stays 0
//   until mret_exec; int_taken while in_service -> cause unchanged.
// - INTC_TIMER_EN, N_SRC=4, ENABLE=0x10, TMR_CMP=5 -> PENDING[4] set every
//   6 cycles; int_taken -> int_cause=4; TMR_CMP=0 -> counter frozen.
// - Assert RST while in_service=1 and PENDING=0x3 -> next edge all zero,
//   INTR=0, CAUSE reads 0.

Source files
------------

// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt controller for the OTTER MCU control FSM.
// External sources are synchronized and rising-edge detected into pending bits,
// masked by an enable register, and presented to the FSM on INTR. The request
// retires on int_taken and the handler window closes on mret_exec.
// Optional feature: define INTC_TIMER_EN to add an internal timer interrupt
// line at index N_SRC with TMR_CMP/TMR_CNT registers at MMIO offsets 3/4.
module intr_ctrl #(
   parameter int N_SRC = 4,
   parameter int TMR_W = 32
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [N_SRC-1:0] src_in,
   input  logic             io_wr,
   input  logic [2:0]       io_addr,
   input  logic [31:0]      io_wdata,
   output logic [31:0]      io_rdata,
   input  logic             int_taken,
   input  logic             mret_exec,
   output logic             INTR,
   output logic             in_service,
   output logic [4:0]       int_cause
);

`ifdef INTC_TIMER_EN
   localparam int NT = N_SRC + 1;
`else
   localparam int NT = N_SRC;
`endif

   typedef enum logic {
      ST_IDLE,
      ST_SERVICE
   } state_t;

   state_t state;
   state_t state_next;

   logic [N_SRC-1:0] sync1;
   logic [N_SRC-1:0] sync2;
   logic [N_SRC-1:0] prev;
   logic [N_SRC-1:0] src_rise;

   logic [NT-1:0] enable;
   logic [NT-1:0] pending;
   logic [NT-1:0] eligible;
   logic [NT-1:0] set_vec;
   logic [NT-1:0] take_clr;
   logic [NT-1:0] w1c;

   logic [4:0] cause;
   logic [4:0] sel;
   logic       take;

   // Only some write-data bits land in registers; this keeps the rest visibly consumed.
   logic unused_wdata;
   assign unused_wdata = ^io_wdata;

   // Two-flop synchronizer plus one history flop for rising-edge detection.
   always_ff @(posedge clk) begin
      if (RST) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= src_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign src_rise = sync2 & ~prev;
   assign eligible = pending & enable;
   assign in_service = (state == ST_SERVICE);
   assign INTR = (|eligible) & ~in_service;
   assign int_cause = cause;
   assign take = int_taken & (|eligible) & ~in_service;
   assign w1c = (io_wr && io_addr == 3'd1) ? io_wdata[NT-1:0] : '0;

`ifdef INTC_TIMER_EN
   logic [TMR_W-1:0] tmr_cnt;
   logic [TMR_W-1:0] tmr_cmp;
   logic             tmr_wr;
   logic             tmr_hit;

   assign tmr_wr  = io_wr && (io_addr == 3'd3 || io_addr == 3'd4);
   assign tmr_hit = !tmr_wr && (tmr_cmp != '0) && (tmr_cnt == tmr_cmp);
   assign set_vec = {tmr_hit, src_rise};

   // Free-running compare timer; a software write freezes the count for that cycle.
   always_ff @(posedge clk) begin
      if (RST) begin
         tmr_cnt <= '0;
         tmr_cmp <= '0;
      end else if (io_wr && io_addr == 3'd4) begin
         tmr_cnt <= TMR_W'(io_wdata);
      end else if (io_wr && io_addr == 3'd3) begin
         tmr_cmp <= TMR_W'(io_wdata);
      end else if (tmr_hit) begin
         tmr_cnt <= '0;
      end else if (tmr_cmp != '0) begin
         tmr_cnt <= tmr_cnt + TMR_W'(1);
      end
   end
`else
   assign set_vec = src_rise;
`endif

   // Priority encoder: the lowest eligible index wins.
   always_comb begin
      sel = '0;
      for (int i = NT - 1; i >= 0; i--) begin
         if (eligible[i]) sel = 5'(i);
      end
   end

   // One-hot clear of the line being acknowledged.
   always_comb begin
      take_clr = '0;
      for (int i = 0; i < NT; i++) begin
         take_clr[i] = take && (sel == 5'(i));
      end
   end

   // Service state register.
   always_ff @(posedge clk) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Enter service on an accepted ack, leave on MRET.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (take) state_next = ST_SERVICE;
         ST_SERVICE: if (mret_exec) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Enable mask, pending latch (new edges override clears) and captured cause.
   always_ff @(posedge clk) begin
      if (RST) begin
         enable  <= '0;
         pending <= '0;
         cause   <= '0;
      end else begin
         if (io_wr && io_addr == 3'd0) enable <= io_wdata[NT-1:0];
         pending <= (pending & ~w1c & ~take_clr) | set_vec;
         if (take) cause <= sel;
      end
   end

   // MMIO read mux, unused bits and unmapped offsets return zero.
   always_comb begin
      io_rdata = '0;
      case (io_addr)
         3'd0: io_rdata = 32'(enable);
         3'd1: io_rdata = 32'(pending);
         3'd2: io_rdata = {in_service, 26'b0, cause};
`ifdef INTC_TIMER_EN
         3'd3: io_rdata = 32'(tmr_cmp);
         3'd4: io_rdata = 32'(tmr_cnt);
`endif
         default: io_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed scenarios followed by randomized traffic for intr_ctrl,
// every output compared against a behavioural model of the controller.
module tb_intr_ctrl;

   localparam int N_SRC = 4;
`ifdef INTC_TIMER_EN
   localparam int NT = N_SRC + 1;
`else
   localparam int NT = N_SRC;
`endif
   localparam logic [31:0] MASK = 32'((64'd1 << NT) - 1);

   logic             clk = 1'b0;
   logic             RST;
   logic [N_SRC-1:0] src_in;
   logic             io_wr;
   logic [2:0]       io_addr;
   logic [31:0]      io_wdata;
   logic [31:0]      io_rdata;
   logic             int_taken;
   logic             mret_exec;
   logic             INTR;
   logic             in_service;
   logic [4:0]       int_cause;

   int checks = 0;
   int failures = 0;

   // Model state.
   logic [31:0]      mEn;
   logic [31:0]      mPend;
   logic [31:0]      mCnt;
   logic [31:0]      mCmp;
   logic             mBusy;
   logic [4:0]       mCause;
   logic [N_SRC-1:0] hist[$];

   intr_ctrl #(.N_SRC(N_SRC), .TMR_W(32)) dut (
      .clk(clk),
      .RST(RST),
      .src_in(src_in),
      .io_wr(io_wr),
      .io_addr(io_addr),
      .io_wdata(io_wdata),
      .io_rdata(io_rdata),
      .int_taken(int_taken),
      .mret_exec(mret_exec),
      .INTR(INTR),
      .in_service(in_service),
      .int_cause(int_cause)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Absolute time limit so the bench cannot hang.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] time limit reached");
   end

   // Advance the model by one clock edge from the inputs present at that edge.
   function automatic void modelStep();
      logic [31:0]      setv;
      logic [31:0]      e;
      logic [31:0]      w1c;
      logic [31:0]      clr;
      logic [N_SRC-1:0] cur;
      logic [N_SRC-1:0] old;
      logic             hit;
      logic             take;
      int               sel;
      int               l;
      if (RST) begin
         mEn = 0; mPend = 0; mCnt = 0; mCmp = 0; mBusy = 0; mCause = 0;
         hist.delete();
         return;
      end
      hist.push_back(src_in);
      if (hist.size() > 4) void'(hist.pop_front());
      l = hist.size() - 1;
      setv = 0;
      if (l >= 2) begin
         cur = hist[l-2];
         old = (l >= 3) ? hist[l-3] : '0;
         setv = 32'(cur & ~old);
      end
      hit = 1'b0;
`ifdef INTC_TIMER_EN
      if (io_wr && io_addr == 3'd4) mCnt = io_wdata;
      else if (io_wr && io_addr == 3'd3) mCmp = io_wdata;
      else if (mCmp != 0) begin
         if (mCnt == mCmp) begin
            mCnt = 0;
            hit = 1'b1;
         end else begin
            mCnt = mCnt + 1;
         end
      end
`endif
      if (hit) setv = setv | (32'd1 << N_SRC);
      e = mPend & mEn;
      take = int_taken && (e != 0) && !mBusy;
      sel = 0;
      for (int i = 0; i < NT; i++) begin
         if (e[i]) begin
            sel = i;
            break;
         end
      end
      clr = take ? (32'd1 << sel) : 32'd0;
      w1c = (io_wr && io_addr == 3'd1) ? (io_wdata & MASK) : 32'd0;
      if (io_wr && io_addr == 3'd0) mEn = io_wdata & MASK;
      mPend = (mPend & ~w1c & ~clr) | setv;
      if (take) begin
         mBusy = 1'b1;
         mCause = 5'(sel);
      end else if (mret_exec) begin
         mBusy = 1'b0;
      end
   endfunction

   function automatic logic [31:0] modelRead(input logic [2:0] a);
      case (a)
         3'd0: return mEn;
         3'd1: return mPend;
         3'd2: return {mBusy, 26'b0, mCause};
`ifdef INTC_TIMER_EN
         3'd3: return mCmp;
         3'd4: return mCnt;
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock edge, then compare the FSM-facing outputs with the model.
   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("intr", {31'b0, INTR}, {31'b0, ((mPend & mEn) != 0) && !mBusy});
      checkOutput("in_service", {31'b0, in_service}, {31'b0, mBusy});
      checkOutput("int_cause", {27'b0, int_cause}, {27'b0, mCause});
   endtask

   task automatic applyStimulus(input logic rst, input logic [N_SRC-1:0] src, input logic wr,
                                input logic [2:0] addr, input logic [31:0] wdata,
                                input logic taken, input logic mret);
      RST = rst; src_in = src; io_wr = wr; io_addr = addr; io_wdata = wdata;
      int_taken = taken; mret_exec = mret;
      tick();
      RST = 1'b0; io_wr = 1'b0; int_taken = 1'b0; mret_exec = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, src_in, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
      applyStimulus(1'b0, src_in, 1'b1, a, d, 1'b0, 1'b0);
   endtask

   task automatic setSrc(input logic [N_SRC-1:0] s);
      applyStimulus(1'b0, s, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic ack();
      applyStimulus(1'b0, src_in, 1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
   endtask

   task automatic mret();
      applyStimulus(1'b0, src_in, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic checkReg(input string tag, input logic [2:0] a);
      io_addr = a;
      #1;
      checkOutput(tag, io_rdata, modelRead(a));
   endtask

   task automatic checkRegConst(input string tag, input logic [2:0] a, input logic [31:0] exp);
      io_addr = a;
      #1;
      checkOutput(tag, io_rdata, exp);
   endtask

   initial begin
      RST = 1'b1; src_in = '0; io_wr = 1'b0; io_addr = '0; io_wdata = '0;
      int_taken = 1'b0; mret_exec = 1'b0;
      mEn = 0; mPend = 0; mCnt = 0; mCmp = 0; mBusy = 0; mCause = 0;

      // Reset values.
      applyStimulus(1'b1, '0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, '0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      for (int a = 0; a < 8; a++) checkRegConst("reset_reg", 3'(a), 32'd0);

      // Single pulse on source 0 reaches INTR on the third edge, then ack.
      writeReg(3'd0, 32'h1);
      setSrc(4'b0001);
      setSrc(4'b0000);
      checkOutput("t1_intr_early", {31'b0, INTR}, 32'd0);
      idle(1);
      checkOutput("t1_intr_third_edge", {31'b0, INTR}, 32'd1);
      ack();
      checkOutput("t1_intr_after_ack", {31'b0, INTR}, 32'd0);
      checkOutput("t1_in_service", {31'b0, in_service}, 32'd1);
      checkRegConst("t1_pending", 3'd1, 32'd0);
      checkRegConst("t1_cause_reg", 3'd2, 32'h8000_0000);
      mret();

      // Simultaneous edges on sources 3 and 1: lowest index served first.
      writeReg(3'd0, 32'hF);
      setSrc(4'b1010);
      idle(2);
      ack();
      checkOutput("t2_cause_first", {27'b0, int_cause}, 32'd1);
      mret();
      checkOutput("t2_intr_again", {31'b0, INTR}, 32'd1);
      ack();
      checkOutput("t2_cause_second", {27'b0, int_cause}, 32'd3);
      mret();
      setSrc(4'b0000);

      // Masked pending persists, enable exposes it, W1C clears it.
      writeReg(3'd0, 32'h0);
      setSrc(4'b0100);
      idle(2);
      checkRegConst("t3_pending_masked", 3'd1, 32'h4);
      checkOutput("t3_intr_masked", {31'b0, INTR}, 32'd0);
      writeReg(3'd0, 32'h4);
      checkOutput("t3_intr_enabled", {31'b0, INTR}, 32'd1);
      writeReg(3'd1, 32'h4);
      checkOutput("t3_intr_cleared", {31'b0, INTR}, 32'd0);
      checkRegConst("t3_pending_cleared", 3'd1, 32'h0);
      setSrc(4'b0000);

      // New request while in service is held off; ack during service is ignored.
      writeReg(3'd0, 32'h3);
      setSrc(4'b0010);
      idle(2);
      ack();
      checkOutput("t4_cause", {27'b0, int_cause}, 32'd1);
      setSrc(4'b0011);
      idle(2);
      checkRegConst("t4_pending_held", 3'd1, 32'h1);
      checkOutput("t4_intr_blocked", {31'b0, INTR}, 32'd0);
      ack();
      checkOutput("t4_cause_unchanged", {27'b0, int_cause}, 32'd1);
      mret();
      checkOutput("t4_intr_after_mret", {31'b0, INTR}, 32'd1);
      ack();
      mret();
      setSrc(4'b0000);

      // Reset in the middle of service with two lines pending.
      writeReg(3'd0, 32'h7);
      setSrc(4'b0100);
      idle(2);
      ack();
      setSrc(4'b0111);
      idle(2);
      checkRegConst("t5_pending_pre", 3'd1, 32'h3);
      applyStimulus(1'b1, src_in, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("t5_intr", {31'b0, INTR}, 32'd0);
      checkOutput("t5_in_service", {31'b0, in_service}, 32'd0);
      checkRegConst("t5_cause_reg", 3'd2, 32'd0);
      checkRegConst("t5_pending", 3'd1, 32'd0);
      checkRegConst("t5_enable", 3'd0, 32'd0);
      idle(3);
      checkRegConst("t5_held_src_pends_once", 3'd1, 32'h7);
      writeReg(3'd1, 32'hFFFF_FFFF);
      setSrc(4'b0000);

`ifdef INTC_TIMER_EN
      // Timer line: compare of 5 gives a request every 6 cycles.
      writeReg(3'd0, 32'h10);
      writeReg(3'd3, 32'd5);
      writeReg(3'd4, 32'd0);
      for (int i = 0; i < 8; i++) begin
         checkReg("tmr_cnt", 3'd4);
         checkReg("tmr_pending", 3'd1);
         idle(1);
      end
      ack();
      checkOutput("tmr_cause", {27'b0, int_cause}, 32'd4);
      mret();
      writeReg(3'd3, 32'd0);
      idle(4);
      checkReg("tmr_frozen", 3'd4);
      writeReg(3'd1, 32'hFFFF_FFFF);
`endif

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         logic [2:0]  a;
         logic [31:0] d;
         logic        w;
         a = 3'($urandom_range(0, 7));
         w = ($urandom_range(0, 5) == 0);
         d = (a == 3'd3 || a == 3'd4) ? 32'($urandom_range(0, 12)) : $urandom;
         applyStimulus(($urandom_range(0, 99) == 0), N_SRC'($urandom), w, a, d,
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
         checkReg("rand_reg", 3'($urandom_range(0, 7)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
